// File: rtl/dfp_mem_responder_if.sv
// dfp_mem_responder_if
// Purpose: bundles the cache downward-facing-port (DFP) line bus together with
//          the responder's status outputs so that the cache side and the
//          memory side can each connect to it through a single port.
// Signals:
//   dfp_addr   [31:0]   line address from the cache (bits [4:0] expected zero)
//   dfp_read            line read request, held until dfp_resp
//   dfp_write           line write request, held until dfp_resp
//   dfp_wdata  [255:0]  write line data
//   dfp_rdata  [255:0]  read line data, non-zero only during a read response
//   dfp_resp            one-cycle completion pulse
//   err                 sticky protocol-error flag
//   rd_count   [15:0]   completed reads (wrapping)
//   wr_count   [15:0]   completed writes (wrapping)
// Modports: master = cache side, slave = memory responder side.
interface dfp_mem_responder_if;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic         err;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp, err, rd_count, wr_count
    );

    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp, err, rd_count, wr_count
    );
endinterface

// File: rtl/dfp_mem_responder.sv
// dfp_mem_responder
// Purpose: line-granular backing memory for the cache DFP. Accepts 256-bit line
//          reads and writebacks, waits LATENCY cycles, commits or returns the
//          line, pulses dfp_resp for one cycle, flags protocol violations and
//          counts completed transactions.
// Parameters:
//   LATENCY    (1..255) cycles from request acceptance to dfp_resp
//   DEPTH_LOG2 log2 of the number of stored 32-byte lines; upper address bits alias
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   bus        dfp_mem_responder_if.slave (request in, response/status out)
module dfp_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    dfp_mem_responder_if.slave    bus
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [7:0] LOAD_VAL  = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [7:0]              r_count;
    logic [26:0]             r_lineAddr;
    logic                    r_opWrite;
    logic [255:0]            r_wdata;
    logic [255:0]            r_rdata;
    logic [255:0]            r_mem [DEPTH];
    logic [DEPTH-1:0]        r_valid;
    logic [15:0]             r_rdCount;
    logic [15:0]             r_wrCount;
    logic                    r_err;

    logic                    w_req;
    logic                    w_reqWrite;
    logic                    w_accept;
    logic                    w_commit;
    logic [DEPTH_LOG2-1:0]   w_index;
    logic                    w_protoErr;

    // A request with both read and write high is serviced as a read.
    assign w_req      = bus.dfp_read | bus.dfp_write;
    assign w_reqWrite = bus.dfp_write & ~bus.dfp_read;
    assign w_accept   = (r_state == IDLE) && w_req;
    // The edge leaving BUSY is where the line is committed or fetched.
    assign w_commit   = (r_state == BUSY) && (r_count == 8'd0);
    assign w_index    = r_lineAddr[DEPTH_LOG2-1:0];

    // Protocol checks: malformed request at acceptance, or the request being
    // dropped or switching op while the transaction is pending.
    always_comb begin
        w_protoErr = 1'b0;
        if (w_accept) begin
            w_protoErr = (bus.dfp_read & bus.dfp_write) | (bus.dfp_addr[4:0] != 5'd0);
        end else if (r_state == BUSY) begin
            w_protoErr = ~w_req | (w_reqWrite != r_opWrite);
        end
    end

    // Every transaction, including LATENCY=1, passes through BUSY with the
    // counter preloaded to LATENCY-1, so dfp_resp always appears LATENCY edges
    // after acceptance and the latched fields are in place before commit.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_req) w_nextState = BUSY;
            BUSY:    if (r_count == 8'd0) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request latching, countdown, response data, valid bits, counters, err.
    // r_rdata is cleared at every edge except the one entering RESP on a read,
    // so it is only non-zero while dfp_resp is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 8'd0;
            r_lineAddr <= 27'd0;
            r_opWrite  <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_valid    <= '0;
            r_rdCount  <= 16'd0;
            r_wrCount  <= 16'd0;
            r_err      <= 1'b0;
        end else begin
            r_rdata <= '0;
            if (w_accept) begin
                r_count    <= LOAD_VAL;
                r_lineAddr <= bus.dfp_addr[31:5];
                r_opWrite  <= w_reqWrite;
                if (w_reqWrite) begin
                    r_wdata <= bus.dfp_wdata;
                end
            end else if ((r_state == BUSY) && (r_count != 8'd0)) begin
                r_count <= r_count - 8'd1;
            end
            if (w_commit) begin
                if (r_opWrite) begin
                    r_valid[w_index] <= 1'b1;
                end else if (r_valid[w_index]) begin
                    r_rdata <= r_mem[w_index];
                end else begin
                    r_rdata <= {8{r_lineAddr, 5'b00000}};
                end
            end
            if (r_state == RESP) begin
                if (r_opWrite) begin
                    r_wrCount <= r_wrCount + 16'd1;
                end else begin
                    r_rdCount <= r_rdCount + 16'd1;
                end
            end
            if (w_protoErr) begin
                r_err <= 1'b1;
            end
        end
    end

    // Line storage survives reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (w_commit && r_opWrite) begin
            r_mem[w_index] <= r_wdata;
        end
    end

    assign bus.dfp_resp  = (r_state == RESP);
    assign bus.dfp_rdata = r_rdata;
    assign bus.err       = r_err;
    assign bus.rd_count  = r_rdCount;
    assign bus.wr_count  = r_wrCount;

endmodule

// File: tb/tb_dfp_mem_responder.sv
// tb_dfp_mem_responder
// Purpose: directed self-checking bench for dfp_mem_responder. Three instances
//          (LATENCY 4, 1 and 8) share one cache-side request driver, each with
//          its own reset; a select picks which instance's outputs are observed.
// Ports: none (top-level bench).
module tb_dfp_mem_responder;

    logic         clk;
    logic         rst4;
    logic         rst1;
    logic         rst8;
    logic [31:0]  tAddr;
    logic         tRead;
    logic         tWrite;
    logic [255:0] tWdata;
    int           sel;

    logic         sResp;
    logic [255:0] sRdata;
    logic         sErr;
    logic [15:0]  sRd;
    logic [15:0]  sWr;

    int checks;
    int fails;
    int pulses4;
    int pulses1;
    int pulses8;

    dfp_mem_responder_if bus4 ();
    dfp_mem_responder_if bus1 ();
    dfp_mem_responder_if bus8 ();

    assign bus4.dfp_addr  = tAddr;
    assign bus4.dfp_read  = tRead;
    assign bus4.dfp_write = tWrite;
    assign bus4.dfp_wdata = tWdata;
    assign bus1.dfp_addr  = tAddr;
    assign bus1.dfp_read  = tRead;
    assign bus1.dfp_write = tWrite;
    assign bus1.dfp_wdata = tWdata;
    assign bus8.dfp_addr  = tAddr;
    assign bus8.dfp_read  = tRead;
    assign bus8.dfp_write = tWrite;
    assign bus8.dfp_wdata = tWdata;

    dfp_mem_responder #(.LATENCY(4), .DEPTH_LOG2(6)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
    dfp_mem_responder #(.LATENCY(1), .DEPTH_LOG2(6)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
    dfp_mem_responder #(.LATENCY(8), .DEPTH_LOG2(6)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed-output select.
    always_comb begin
        case (sel)
            0: begin
                sResp = bus4.dfp_resp; sRdata = bus4.dfp_rdata; sErr = bus4.err;
                sRd = bus4.rd_count; sWr = bus4.wr_count;
            end
            1: begin
                sResp = bus1.dfp_resp; sRdata = bus1.dfp_rdata; sErr = bus1.err;
                sRd = bus1.rd_count; sWr = bus1.wr_count;
            end
            default: begin
                sResp = bus8.dfp_resp; sRdata = bus8.dfp_rdata; sErr = bus8.err;
                sRd = bus8.rd_count; sWr = bus8.wr_count;
            end
        endcase
    end

    // Count response cycles per instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus4.dfp_resp) pulses4++;
        if (bus1.dfp_resp) pulses1++;
        if (bus8.dfp_resp) pulses8++;
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One cache transaction: request appears before edge T0, is held until the
    // cycle after dfp_resp, then dropped. Checks latency, data and pulse width.
    task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr,
                                 input logic [255:0] wdata, input int expLat,
                                 input logic [255:0] expRdata, input bit dropEarly);
        int           lat;
        bit           seen;
        logic [255:0] got;
        lat  = 0;
        seen = 1'b0;
        got  = '0;
        @(negedge clk);
        tAddr  = addr;
        tRead  = rd;
        tWrite = wr;
        tWdata = wdata;
        @(posedge clk);
        if (dropEarly) begin
            #1;
            tRead  = 1'b0;
            tWrite = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sResp) begin
                seen = 1'b1;
                got  = sRdata;
                break;
            end
            lat++;
        end
        checkOutput("resp seen", 256'(seen), 256'(1));
        if (seen) begin
            checkOutput("latency", 256'(lat), 256'(expLat));
            checkOutput("rdata", got, expRdata);
        end
        @(posedge clk);
        #1;
        tRead  = 1'b0;
        tWrite = 1'b0;
        @(negedge clk);
        checkOutput("resp one cycle", 256'(sResp), 256'(0));
    endtask

    initial begin
        int p;
        checks  = 0;
        fails   = 0;
        pulses4 = 0;
        pulses1 = 0;
        pulses8 = 0;
        sel     = 0;
        tAddr   = '0;
        tRead   = 1'b0;
        tWrite  = 1'b0;
        tWdata  = '0;
        rst4    = 1'b1;
        rst1    = 1'b1;
        rst8    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        rst1 = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);

        $display("[TB] reset state, LATENCY=4");
        checkOutput("reset resp", 256'(sResp), 256'(0));
        checkOutput("reset rdata", sRdata, 256'(0));
        checkOutput("reset err", 256'(sErr), 256'(0));
        checkOutput("reset rd_count", 256'(sRd), 256'(0));
        checkOutput("reset wr_count", 256'(sWr), 256'(0));

        p = pulses4;
        $display("[TB] basic read, write, read-back, aliasing");
        applyStimulus(32'h0000_0040, 1'b1, 1'b0, '0, 4, {8{32'h0000_0040}}, 1'b0);
        checkOutput("rd_count after read", 256'(sRd), 256'(1));
        checkOutput("err after read", 256'(sErr), 256'(0));
        applyStimulus(32'h0000_0080, 1'b0, 1'b1, {8{32'hDEAD_BEEF}}, 4, 256'(0), 1'b0);
        checkOutput("wr_count after write", 256'(sWr), 256'(1));
        applyStimulus(32'h0000_0080, 1'b1, 1'b0, '0, 4, {8{32'hDEAD_BEEF}}, 1'b0);
        checkOutput("rd_count after read-back", 256'(sRd), 256'(2));
        applyStimulus(32'h0000_0020, 1'b0, 1'b1, {8{32'h1234_5678}}, 4, 256'(0), 1'b0);
        applyStimulus(32'h0000_0820, 1'b1, 1'b0, '0, 4, {8{32'h1234_5678}}, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("back-to-back pulse count", 256'(pulses4 - p), 256'(5));
        checkOutput("err after clean traffic", 256'(sErr), 256'(0));
        checkOutput("rd_count", 256'(sRd), 256'(3));
        checkOutput("wr_count", 256'(sWr), 256'(2));

        $display("[TB] protocol errors");
        applyStimulus(32'h0000_0080, 1'b1, 1'b1, '0, 4, {8{32'hDEAD_BEEF}}, 1'b0);
        checkOutput("err read+write", 256'(sErr), 256'(1));
        checkOutput("wr_count after read+write", 256'(sWr), 256'(2));
        applyStimulus(32'h0000_0080, 1'b1, 1'b0, '0, 4, {8{32'hDEAD_BEEF}}, 1'b0);
        applyStimulus(32'h0000_0044, 1'b1, 1'b0, '0, 4, {8{32'h0000_0040}}, 1'b0);
        checkOutput("err sticky", 256'(sErr), 256'(1));
        checkOutput("rd_count before reset", 256'(sRd), 256'(6));

        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        @(negedge clk);
        checkOutput("err cleared", 256'(sErr), 256'(0));
        checkOutput("rd_count cleared", 256'(sRd), 256'(0));
        checkOutput("wr_count cleared", 256'(sWr), 256'(0));
        applyStimulus(32'h0000_0080, 1'b1, 1'b0, '0, 4, {8{32'h0000_0080}}, 1'b0);
        applyStimulus(32'h0000_00C0, 1'b1, 1'b0, '0, 4, {8{32'h0000_00C0}}, 1'b1);
        checkOutput("err dropped request", 256'(sErr), 256'(1));

        $display("[TB] LATENCY=1");
        sel = 1;
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        applyStimulus(32'h0000_0040, 1'b1, 1'b0, '0, 1, {8{32'h0000_0040}}, 1'b0);
        applyStimulus(32'h0000_0020, 1'b0, 1'b1, {8{32'hA5A5_0F0F}}, 1, 256'(0), 1'b0);
        applyStimulus(32'h0000_0020, 1'b1, 1'b0, '0, 1, {8{32'hA5A5_0F0F}}, 1'b0);
        checkOutput("L1 rd_count", 256'(sRd), 256'(2));
        checkOutput("L1 wr_count", 256'(sWr), 256'(1));
        checkOutput("L1 err", 256'(sErr), 256'(0));

        $display("[TB] LATENCY=8 reset during BUSY");
        sel = 2;
        @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8   = 1'b0;
        tAddr  = 32'h0000_0060;
        tWrite = 1'b1;
        tWdata = {8{32'hCAFE_F00D}};
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst8   = 1'b1;
        tWrite = 1'b0;
        p      = pulses8;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkOutput("L8 no resp after reset", 256'(pulses8 - p), 256'(0));
        checkOutput("L8 wr_count", 256'(sWr), 256'(0));
        applyStimulus(32'h0000_0060, 1'b1, 1'b0, '0, 8, {8{32'h0000_0060}}, 1'b0);
        checkOutput("L8 rd_count", 256'(sRd), 256'(1));

        $display("[TB] %0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
